// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default byte width and the owner-index width helper.
package uart_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    GAP,
    HOLD
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request at or after the pointer,
// wrapping modulo N_REQ, plus a flag saying whether any request was set.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int OWNER_W = owner_w(N_REQ)
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [OWNER_W-1:0] ptr_i,
  output logic [OWNER_W-1:0] winner_o,
  output logic               valid_o
);

  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!valid_o && req_i[idx[OWNER_W-1:0]]) begin
        valid_o  = 1'b1;
        winner_o = idx[OWNER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte requesters with round-robin
// arbitration, per-requester packet lock, inter-frame gap and done timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  N_REQ      = 4,
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  GAP_CYCLES = 16,
  parameter int  TIMEOUT    = 200000,
  localparam int OWNER_W    = owner_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_lock,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_ack,
  output logic                    o_tx_start,
  output logic [DATA_W-1:0]       o_tx_data,
  input  logic                    i_tx_done,
  output logic [OWNER_W-1:0]      o_owner,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GCNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TCNT_W-1:0]  TCNT_LAST  = TCNT_W'(TIMEOUT - 1);
  localparam logic [GCNT_W-1:0]  GCNT_LAST  = GCNT_W'(GAP_CYCLES - 1);
  localparam logic [OWNER_W-1:0] OWNER_LAST = OWNER_W'(N_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [GCNT_W-1:0]  gcnt_q, gcnt_d;
  logic               abort_q, abort_d;

  logic [OWNER_W-1:0] pickWinner;
  logic               pickValid;
  logic               timeoutHit;
  logic               decide;
  logic [DATA_W-1:0]  reqData [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign reqData[k] = i_data[k*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ   (N_REQ),
    .OWNER_W (OWNER_W)
  ) u_pick (
    .req_i    (i_req),
    .ptr_i    (ptr_q),
    .winner_o (pickWinner),
    .valid_o  (pickValid)
  );

  assign timeoutHit = (state_q == WAIT) && !i_tx_done && (tcnt_q == TCNT_LAST);

  // abort_d marks a frame that timed out, so its lock cannot keep the owner.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    abort_d = abort_q;
    decide  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          owner_d = pickWinner;
          data_d  = reqData[pickWinner];
          state_d = START;
        end
      end
      START: begin
        ptr_d   = (owner_q == OWNER_LAST) ? '0 : owner_q + 1'b1;
        tcnt_d  = '0;
        abort_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (i_tx_done || timeoutHit) begin
          abort_d = timeoutHit;
          gcnt_d  = '0;
          if (GAP_CYCLES == 0) begin
            decide = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gcnt_q == GCNT_LAST) begin
          decide = 1'b1;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (i_req[owner_q]) begin
          data_d  = reqData[owner_q];
          state_d = START;
        end else if (!i_lock[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (decide) begin
      if (i_lock[owner_q] && !abort_d && i_req[owner_q]) begin
        data_d  = reqData[owner_q];
        state_d = START;
      end else if (i_lock[owner_q] && !abort_d) begin
        state_d = HOLD;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    o_ack = '0;
    if (state_q == START) begin
      o_ack[owner_q] = 1'b1;
    end
  end

  assign o_tx_start = (state_q == START);
  assign o_tx_data  = data_q;
  assign o_owner    = owner_q;
  assign o_busy     = (state_q != IDLE);
  assign o_timeout  = timeoutHit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: reset values, latency,
// gap, round-robin order, packet lock, HOLD, timeout and reset mid-frame.
module tb_uart_tx_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_W     = 8;
  localparam int GAP_CYCLES = 16;
  localparam int TIMEOUT    = 1000;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [N_REQ-1:0]        i_req = '0;
  logic [N_REQ-1:0]        i_lock = '0;
  logic [N_REQ*DATA_W-1:0] i_data = '0;
  logic                    i_tx_done = 1'b0;
  logic [N_REQ-1:0]        o_ack;
  logic                    o_tx_start;
  logic [DATA_W-1:0]       o_tx_data;
  logic [1:0]              o_owner;
  logic                    o_busy;
  logic                    o_timeout;

  int testsRun  = 0;
  int failCount = 0;
  int order [5] = '{0, 1, 2, 3, 0};
  int sent  [4];

  uart_tx_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_lock     (i_lock),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .o_owner    (o_owner),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] data);
    i_req[k] = 1'b1;
    i_data[k*DATA_W +: DATA_W] = data;
  endtask

  task automatic applyReset();
    reset     = 1'b0;
    i_req     = '0;
    i_lock    = '0;
    i_data    = '0;
    i_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Waits for the next start pulse, then checks owner, byte, ack and latency.
  task automatic grantCheck(input string tag, input int expOwner, input logic [7:0] expData, input int expWait);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!o_tx_start && waited < 1500);
    checkOutput({tag, "_start"}, 32'(o_tx_start), 32'd1);
    if (expWait >= 0) checkOutput({tag, "_latency"}, 32'(waited), 32'(expWait));
    checkOutput({tag, "_owner"}, 32'(o_owner), 32'(expOwner));
    checkOutput({tag, "_data"}, 32'(o_tx_data), 32'(expData));
    checkOutput({tag, "_ack"}, 32'(o_ack), 32'(1) << expOwner);
  endtask

  task automatic pulseDone(input int delay);
    repeat (delay) @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  // Every ack must be one-hot, coincide with start and point at the owner.
  always @(negedge clk) begin
    if (reset && (o_tx_start || o_ack != '0)) begin
      checkOutput("ack_match", 32'(o_ack), o_tx_start ? (32'(1) << o_owner) : 32'd0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int startSeen;

    // Reset values while reset is held low.
    @(negedge clk);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_start", 32'(o_tx_start), 32'd0);
    checkOutput("rst_ack", 32'(o_ack), 32'd0);
    checkOutput("rst_data", 32'(o_tx_data), 32'd0);
    checkOutput("rst_owner", 32'(o_owner), 32'd0);
    checkOutput("rst_timeout", 32'(o_timeout), 32'd0);

    // Single request: one-cycle latency, then a second grant after the gap.
    applyReset();
    applyStimulus(2, 8'hA5);
    grantCheck("single", 2, 8'hA5, 1);
    i_req[2] = 1'b0;
    checkOutput("single_busy", 32'(o_busy), 32'd1);
    repeat (99) @(negedge clk);
    i_tx_done = 1'b1;
    applyStimulus(0, 8'h5E);
    @(negedge clk);
    i_tx_done = 1'b0;
    grantCheck("single_gap", 0, 8'h5E, 17);
    i_req[0] = 1'b0;
    pulseDone(4);
    repeat (20) @(negedge clk);

    // Round-robin with all four requesting continuously.
    applyReset();
    for (int k = 0; k < N_REQ; k++) begin
      sent[k] = 0;
      applyStimulus(k, 8'(k * 16));
    end
    for (int n = 0; n < 5; n++) begin
      int k;
      k = order[n];
      grantCheck($sformatf("rr%0d", n), k, 8'(k * 16 + sent[k]), -1);
      sent[k]++;
      i_data[k*DATA_W +: DATA_W] = 8'(k * 16 + sent[k]);
      if (n == 4) i_req = '0;
      pulseDone(3);
      if (n < 4) checkOutput($sformatf("rr_busy%0d", n), 32'(o_busy), 32'd1);
    end
    repeat (16) @(negedge clk);
    checkOutput("rr_idle", 32'(o_busy), 32'd0);

    // Lock: requester 1 sends 11,22,33 back to back, then 3, then 0.
    applyReset();
    applyStimulus(1, 8'h11);
    i_lock[1] = 1'b1;
    grantCheck("lock_b1", 1, 8'h11, 1);
    applyStimulus(0, 8'hA0);
    applyStimulus(3, 8'hD3);
    i_data[1*DATA_W +: DATA_W] = 8'h22;
    pulseDone(5);
    grantCheck("lock_b2", 1, 8'h22, 16);
    i_data[1*DATA_W +: DATA_W] = 8'h33;
    pulseDone(5);
    grantCheck("lock_b3", 1, 8'h33, 16);
    i_req[1]  = 1'b0;
    i_lock[1] = 1'b0;
    pulseDone(5);
    grantCheck("lock_next3", 3, 8'hD3, 17);
    i_req[3] = 1'b0;
    pulseDone(5);
    grantCheck("lock_next0", 0, 8'hA0, 17);
    i_req[0] = 1'b0;
    pulseDone(5);
    repeat (20) @(negedge clk);

    // HOLD: locked owner goes quiet, other requesters must wait.
    applyReset();
    applyStimulus(2, 8'h2A);
    i_lock[2] = 1'b1;
    grantCheck("hold_b1", 2, 8'h2A, 1);
    i_req[2] = 1'b0;
    applyStimulus(0, 8'h0B);
    pulseDone(5);
    startSeen = 0;
    repeat (60) begin
      @(negedge clk);
      if (o_tx_start) startSeen++;
    end
    checkOutput("hold_nostart", 32'(startSeen), 32'd0);
    checkOutput("hold_busy", 32'(o_busy), 32'd1);
    i_lock[2] = 1'b0;
    grantCheck("hold_release", 0, 8'h0B, 2);
    i_req[0] = 1'b0;
    pulseDone(5);
    repeat (20) @(negedge clk);

    // Timeout: no done, lock released, requester 3 wins after the gap.
    applyReset();
    applyStimulus(1, 8'h5A);
    i_lock[1] = 1'b1;
    grantCheck("to_b1", 1, 8'h5A, 1);
    applyStimulus(3, 8'h3C);
    i_data[1*DATA_W +: DATA_W] = 8'h5B;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!o_timeout && waited < 1100);
    checkOutput("to_pulse", 32'(o_timeout), 32'd1);
    checkOutput("to_cycles", 32'(waited), 32'(TIMEOUT));
    grantCheck("to_next", 3, 8'h3C, 18);
    i_req  = '0;
    i_lock = '0;
    pulseDone(5);
    repeat (20) @(negedge clk);

    // Reset in the middle of WAIT, followed by a stray done.
    applyReset();
    applyStimulus(0, 8'h77);
    grantCheck("rmid_b1", 0, 8'h77, 1);
    i_req[0] = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rmid_busy", 32'(o_busy), 32'd0);
    checkOutput("rmid_data", 32'(o_tx_data), 32'd0);
    checkOutput("rmid_owner", 32'(o_owner), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    startSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_tx_start) startSeen++;
    end
    checkOutput("rmid_nostart", 32'(startSeen), 32'd0);
    checkOutput("rmid_idle", 32'(o_busy), 32'd0);
    checkOutput("rmid_timeout", 32'(o_timeout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
